// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//
// Receiving end of a toggle-line event protocol. The sender is a T flip-flop
// whose output inverts once per event; this block synchronizes that line,
// turns every level change into a one-cycle event pulse, mirrors the
// sender's q/qbar pair, and keeps a saturating event count plus a pending
// flag that a consumer acknowledges.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on tog_in (legal 2..4)
//   CNT_W        event counter width (legal 2..16)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset, overrides all inputs
//   tog_in       in   toggle line from the sender; each level change = one event
//   ack          in   consumer acknowledge of the pending event
//   clr          in   synchronous clear of count, overflow and lost
//   event_pulse  out  one-cycle pulse per decoded event
//   q            out  decoded sender level
//   qbar         out  complement of q
//   pending      out  an event is waiting for ack
//   lost         out  sticky: event arrived while pending=1 and ack=0
//   count        out  saturating count of decoded events
//   overflow     out  sticky: event arrived while count was at its maximum
//
// Handshake: pending is the "valid" side and ack the "ready" side. An event
// raises pending; pending falls only on an edge where ack=1 and no new event
// arrives. ack together with a new event consumes the old event and leaves
// pending high for the new one. ack while pending=0 has no effect. An event
// arriving while pending=1 and ack=0 overwrites the unconsumed one and sets
// the sticky lost flag.
//
// There is no FSM in this block; all state is visible on the outputs.

module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    input  logic             ack,
    input  logic             clr,
    output logic             event_pulse,
    output logic             q,
    output logic             qbar,
    output logic             pending,
    output logic             lost,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   e;

    // Oldest stage of the chain is the synchronized sender level.
    assign s = sync_q[SYNC_STAGES-1];
    // q holds the last decoded level, so any difference is a new event.
    assign e = s ^ q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            q           <= 1'b0;
            qbar        <= 1'b1;
            event_pulse <= 1'b0;
            pending     <= 1'b0;
            lost        <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tog_in};
            q           <= s;
            // Registered separately (not ~q) so qbar is a flop output too.
            qbar        <= ~s;
            event_pulse <= e;

            // Counter: clr restarts from this edge's event, so a coincident
            // event is still counted.
            if (clr) begin
                count    <= {{(CNT_W-1){1'b0}}, e};
                overflow <= 1'b0;
            end else if (e) begin
                if (count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end

            // Pending/ack handshake; clr does not touch pending.
            if (e) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end

            // clr wins over a coincident loss.
            if (clr) begin
                lost <= 1'b0;
            end else if (e && pending && !ack) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder. Three instances share the same
// stimulus: default (SYNC_STAGES=2, CNT_W=8), a 3-stage synchronizer, and a
// 4-bit counter for saturation. Inputs are driven 1 time unit after a rising
// edge and outputs are checked at that same point, away from the edge.

module tb_toggle_event_decoder;

    logic clk;
    logic reset;
    logic tog_in;
    logic ack;
    logic clr;

    logic       d_pulse, d_q, d_qbar, d_pend, d_lost, d_ovf;
    logic [7:0] d_cnt;
    logic       t_pulse, t_q, t_qbar, t_pend, t_lost, t_ovf;
    logic [7:0] t_cnt;
    logic       s_pulse, s_q, s_qbar, s_pend, s_lost, s_ovf;
    logic [3:0] s_cnt;

    int errors = 0;
    int checks = 0;

    toggle_event_decoder u_dut (
        .clk(clk), .reset(reset), .tog_in(tog_in), .ack(ack), .clr(clr),
        .event_pulse(d_pulse), .q(d_q), .qbar(d_qbar), .pending(d_pend),
        .lost(d_lost), .count(d_cnt), .overflow(d_ovf)
    );

    toggle_event_decoder #(.SYNC_STAGES(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset(reset), .tog_in(tog_in), .ack(ack), .clr(clr),
        .event_pulse(t_pulse), .q(t_q), .qbar(t_qbar), .pending(t_pend),
        .lost(t_lost), .count(t_cnt), .overflow(t_ovf)
    );

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .tog_in(tog_in), .ack(ack), .clr(clr),
        .event_pulse(s_pulse), .q(s_q), .qbar(s_qbar), .pending(s_pend),
        .lost(s_lost), .count(s_cnt), .overflow(s_ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tog_in = 1'b0;
        ack    = 1'b0;
        clr    = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1; tog_in = 1'b1; ack = 1'b1; clr = 1'b1;
        tick();
        tick();
        if (d_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", d_pulse); end checks++;
        if (d_q !== 1'b0) begin errors++; $display("FAIL reset_q got %b exp 0", d_q); end checks++;
        if (d_qbar !== 1'b1) begin errors++; $display("FAIL reset_qbar got %b exp 1", d_qbar); end checks++;
        if (d_pend !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", d_pend); end checks++;
        if (d_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b exp 0", d_lost); end checks++;
        if (d_cnt !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", d_cnt); end checks++;
        if (d_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", d_ovf); end checks++;
        if (t_qbar !== 1'b1 || t_q !== 1'b0) begin errors++; $display("FAIL reset_dut3_q got q=%b qbar=%b exp q=0 qbar=1", t_q, t_qbar); end checks++;
        if (s_cnt !== 4'd0 || s_pend !== 1'b0) begin errors++; $display("FAIL reset_sat got cnt=%0d pend=%b exp 0/0", s_cnt, s_pend); end checks++;
    endtask

    task automatic test_single_event();
        apply_reset();
        repeat (3) tick();
        tog_in = 1'b1;
        // Edge 1 samples tog_in; default decodes at edge 3, 3-stage at edge 4.
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (d_pulse !== (i == 3)) begin errors++; $display("FAIL single_pulse edge %0d got %b exp %b", i, d_pulse, (i == 3)); end checks++;
            if (t_pulse !== (i == 4)) begin errors++; $display("FAIL single_pulse3 edge %0d got %b exp %b", i, t_pulse, (i == 4)); end checks++;
            if (i == 3) begin
                if (d_cnt !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", d_cnt); end checks++;
                if (d_pend !== 1'b1) begin errors++; $display("FAIL single_pending got %b exp 1", d_pend); end checks++;
                if (d_q !== 1'b1 || d_qbar !== 1'b0) begin errors++; $display("FAIL single_q got q=%b qbar=%b exp 1/0", d_q, d_qbar); end checks++;
                if (d_lost !== 1'b0) begin errors++; $display("FAIL single_lost got %b exp 0", d_lost); end checks++;
                if (t_q !== 1'b0) begin errors++; $display("FAIL single_q3_early got %b exp 0", t_q); end checks++;
            end
        end
        if (t_cnt !== 8'd1 || t_q !== 1'b1) begin errors++; $display("FAIL single_dut3 got cnt=%0d q=%b exp 1/1", t_cnt, t_q); end checks++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 5) tog_in = ~tog_in;
            tick();
            if (d_pulse !== (i >= 3 && i <= 7)) begin errors++; $display("FAIL burst_pulse edge %0d got %b", i, d_pulse); end checks++;
            if (t_pulse !== (i >= 4 && i <= 8)) begin errors++; $display("FAIL burst_pulse3 edge %0d got %b", i, t_pulse); end checks++;
        end
        if (d_cnt !== 8'd5) begin errors++; $display("FAIL burst_count got %0d exp 5", d_cnt); end checks++;
        if (d_pend !== 1'b1) begin errors++; $display("FAIL burst_pending got %b exp 1", d_pend); end checks++;
        if (d_lost !== 1'b1) begin errors++; $display("FAIL burst_lost got %b exp 1", d_lost); end checks++;
        if (d_q !== 1'b1) begin errors++; $display("FAIL burst_q got %b exp 1", d_q); end checks++;
        if (t_cnt !== 8'd5 || t_lost !== 1'b1) begin errors++; $display("FAIL burst_dut3 got cnt=%0d lost=%b exp 5/1", t_cnt, t_lost); end checks++;
    endtask

    task automatic test_handshake();
        apply_reset();
        tog_in = 1'b1;
        repeat (3) tick();
        if (d_pend !== 1'b1) begin errors++; $display("FAIL hs_first_pending got %b exp 1", d_pend); end checks++;
        tog_in = 1'b0;
        tick();
        tick();
        ack = 1'b1;
        tick();   // second event decoded on this edge together with ack
        ack = 1'b0;
        if (d_pulse !== 1'b1) begin errors++; $display("FAIL hs_coincident_pulse got %b exp 1", d_pulse); end checks++;
        if (d_pend !== 1'b1) begin errors++; $display("FAIL hs_coincident_pending got %b exp 1", d_pend); end checks++;
        if (d_lost !== 1'b0) begin errors++; $display("FAIL hs_coincident_lost got %b exp 0", d_lost); end checks++;
        if (d_cnt !== 8'd2) begin errors++; $display("FAIL hs_coincident_count got %0d exp 2", d_cnt); end checks++;
        tick();
        tick();
        if (d_pend !== 1'b1) begin errors++; $display("FAIL hs_hold_pending got %b exp 1", d_pend); end checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (d_pend !== 1'b0) begin errors++; $display("FAIL hs_ack_pending got %b exp 0", d_pend); end checks++;
        if (d_cnt !== 8'd2) begin errors++; $display("FAIL hs_ack_count got %0d exp 2", d_cnt); end checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (d_pend !== 1'b0 || d_lost !== 1'b0) begin errors++; $display("FAIL hs_idle_ack got pend=%b lost=%b exp 0/0", d_pend, d_lost); end checks++;
    endtask

    task automatic test_saturation_clear();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            tog_in = ~tog_in;
            tick();
        end
        repeat (3) tick();
        if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat15_count got %0d exp 15", s_cnt); end checks++;
        if (s_ovf !== 1'b0) begin errors++; $display("FAIL sat15_overflow got %b exp 0", s_ovf); end checks++;
        for (int i = 0; i < 2; i++) begin
            tog_in = ~tog_in;
            tick();
        end
        repeat (3) tick();
        if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat17_count got %0d exp 15", s_cnt); end checks++;
        if (s_ovf !== 1'b1) begin errors++; $display("FAIL sat17_overflow got %b exp 1", s_ovf); end checks++;
        if (d_cnt !== 8'd17 || d_ovf !== 1'b0) begin errors++; $display("FAIL wide17 got cnt=%0d ovf=%b exp 17/0", d_cnt, d_ovf); end checks++;
        tog_in = ~tog_in;
        tick();
        tick();
        clr = 1'b1;
        tick();   // event and clr on the same edge
        clr = 1'b0;
        if (s_cnt !== 4'd1) begin errors++; $display("FAIL clr_count got %0d exp 1", s_cnt); end checks++;
        if (s_ovf !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b exp 0", s_ovf); end checks++;
        if (s_lost !== 1'b0) begin errors++; $display("FAIL clr_lost got %b exp 0", s_lost); end checks++;
        if (s_pend !== 1'b1) begin errors++; $display("FAIL clr_pending got %b exp 1", s_pend); end checks++;
        if (d_cnt !== 8'd1) begin errors++; $display("FAIL clr_wide_count got %0d exp 1", d_cnt); end checks++;
        tog_in = ~tog_in;
        repeat (3) tick();
        if (s_cnt !== 4'd2 || s_ovf !== 1'b0) begin errors++; $display("FAIL post_clr got cnt=%0d ovf=%b exp 2/0", s_cnt, s_ovf); end checks++;
    endtask

    task automatic test_reset_mid_op();
        int n_d;
        int n_t;
        int first_d;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tog_in = ~tog_in;
            tick();
        end
        repeat (3) tick();
        if (d_cnt !== 8'd7 || tog_in !== 1'b1) begin errors++; $display("FAIL mid_pre_count got %0d exp 7", d_cnt); end checks++;
        reset = 1'b1;
        tick();
        if (d_cnt !== 8'd0 || d_q !== 1'b0 || d_qbar !== 1'b1) begin errors++; $display("FAIL mid_reset_state got cnt=%0d q=%b qbar=%b exp 0/0/1", d_cnt, d_q, d_qbar); end checks++;
        if (d_pend !== 1'b0 || d_lost !== 1'b0 || d_pulse !== 1'b0 || d_ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got pend=%b lost=%b pulse=%b ovf=%b exp 0", d_pend, d_lost, d_pulse, d_ovf); end checks++;
        reset = 1'b0;
        n_d = 0; n_t = 0; first_d = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (d_pulse) begin
                n_d++;
                if (first_d == 0) first_d = i;
            end
            if (t_pulse) n_t++;
        end
        if (n_d !== 1) begin errors++; $display("FAIL mid_release_pulses got %0d exp 1", n_d); end checks++;
        if (first_d !== 3) begin errors++; $display("FAIL mid_release_edge got %0d exp 3", first_d); end checks++;
        if (n_t !== 1) begin errors++; $display("FAIL mid_release_pulses3 got %0d exp 1", n_t); end checks++;
        if (d_cnt !== 8'd1 || d_q !== 1'b1) begin errors++; $display("FAIL mid_release_count got cnt=%0d q=%b exp 1/1", d_cnt, d_q); end checks++;
    endtask

    initial begin
        reset = 1'b1; tog_in = 1'b0; ack = 1'b0; clr = 1'b0;
        test_reset();
        test_single_event();
        test_back_to_back();
        test_handshake();
        test_saturation_clear();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
